// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS pipeline, including the fetch-stage additions.
//   reg_t / inst_t   : 32-bit register and instruction word types
//   if_state_enum    : fetch-stage FSM states
//   fetch_entry_t    : one fetched word together with its PC
//   IF_BUF_DEPTH     : depth of the fetch queue between IF and ID
package mips_cpu_pkg;

  typedef logic [31:0] reg_t;
  typedef logic [31:0] inst_t;

  localparam int IF_BUF_DEPTH = 2;

  // Wide enough to hold 0..IF_BUF_DEPTH.
  typedef logic [1:0] buf_cnt_t;

  typedef enum logic [1:0] {
    RST_HOLD,
    FETCH,
    HOLD,
    DISCARD
  } if_state_enum;

  typedef struct packed {
    reg_t  pc;
    inst_t inst;
  } fetch_entry_t;

  // Clear the byte-offset bits so the address is word aligned.
  function automatic reg_t word_align(input reg_t addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/stage_if_fetch_buf.sv
// fetch_buf: 2-entry FIFO of fetch_entry_t between the fetch FSM and ID.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push/entry  : write entry at the tail
//   pop         : drop the head (caller guarantees count != 0)
//   clear       : empty the queue; wins over push and pop
//   count       : number of valid entries (0..IF_BUF_DEPTH)
//   head        : entry 0, registered storage (no path from push data)
module fetch_buf
  import mips_cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  output buf_cnt_t     count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [IF_BUF_DEPTH];
  fetch_entry_t mem_d [IF_BUF_DEPTH];
  buf_cnt_t     count_q;
  buf_cnt_t     count_d;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          mem_d[count_q[0]] = push_entry;
          count_d           = count_q + 2'd1;
        end
        2'b01: begin
          mem_d[0] = mem_q[1];
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            mem_d[0] = push_entry;
          end else begin
            mem_d[0] = mem_q[1];
            mem_d[1] = push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < IF_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[0];

endmodule

// File: rtl/stage_if.sv
// stage_if: instruction-fetch stage. Holds the PC, runs a single-outstanding
// req/ack handshake to instruction memory and queues returned words (with
// their PCs) for the decode stage through a valid/ready handshake.
//   cpu_clk_50M, cpu_rst_n    : clock, asynchronous active-low reset
//   ireq, iaddr, iack, irdata : instruction memory handshake
//   flush, redirect_pc        : discard queued/in-flight fetches, restart
//   if_o_valid, if_i_ready    : queue-head handshake towards regs_ifid
//   if_o_inst, if_o_pc        : queue-head word and its PC
module stage_if
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  output logic        ireq,
  output logic [31:0] iaddr,
  input  logic        iack,
  input  logic [31:0] irdata,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        if_o_valid,
  input  logic        if_i_ready,
  output inst_t       if_o_inst,
  output logic [31:0] if_o_pc
);

  if_state_enum state_q, state_d;
  reg_t         pc_q, pc_d;              // address of the current/next fetch
  reg_t         redirect_q, redirect_d;  // target held while in DISCARD

  logic         push, pop;
  buf_cnt_t     count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  reg_t         flush_pc;

  assign ireq       = (state_q == FETCH) || (state_q == DISCARD);
  assign iaddr      = pc_q;
  assign if_o_valid = (count != '0);
  assign flush_pc   = word_align(redirect_pc);
  assign push_entry = '{pc: pc_q, inst: irdata};
  // Flush has priority, so a pop in the flush cycle is suppressed.
  assign pop        = if_o_valid && if_i_ready && !flush;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    push       = 1'b0;
    unique case (state_q)
      RST_HOLD: begin
        state_d = FETCH;
        if (flush) pc_d = flush_pc;
      end
      FETCH: begin
        if (flush) begin
          if (iack) begin
            pc_d = flush_pc;
          end else begin
            // Request stays on the bus; remember where to go once it returns.
            redirect_d = flush_pc;
            state_d    = DISCARD;
          end
        end else if (iack) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
          // Queue fills when one entry stays and this word joins it.
          if (count == 2'd1 && !pop) state_d = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          pc_d    = flush_pc;
          state_d = FETCH;
        end else if (pop || count < 2'(IF_BUF_DEPTH)) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (flush) redirect_d = flush_pc;
        if (iack) begin
          state_d = FETCH;
          pc_d    = flush ? flush_pc : redirect_q;
        end
      end
      default: state_d = RST_HOLD;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q    <= RST_HOLD;
      pc_q       <= RESET_PC;
      redirect_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  fetch_buf u_fetch_buf (
    .clk        (cpu_clk_50M),
    .rst_n      (cpu_rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (flush),
    .count      (count),
    .head       (head)
  );

  assign if_o_inst = head.inst;
  assign if_o_pc   = head.pc;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed scenarios followed by randomized traffic, all
// checked every cycle against a transaction-level model (queue of fetched
// words, one outstanding request, a "drop next ack" flag after flush).
module tb_stage_if;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ireq;
  logic [31:0] iaddr;
  logic        iack = 1'b0;
  logic [31:0] irdata = '0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_o_valid;
  logic        if_i_ready = 1'b0;
  logic [31:0] if_o_inst;
  logic [31:0] if_o_pc;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stage_if #(.RESET_PC(RESET_PC)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .ireq        (ireq),
    .iaddr       (iaddr),
    .iack        (iack),
    .irdata      (irdata),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .if_o_valid  (if_o_valid),
    .if_i_ready  (if_i_ready),
    .if_o_inst   (if_o_inst),
    .if_o_pc     (if_o_pc)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  bit          m_req;      // a request is on the bus
  bit          m_discard;  // the outstanding request's data must be dropped
  logic [31:0] m_addr;     // address of the outstanding request
  logic [31:0] m_next;     // address of the next request to issue

  task automatic model_reset();
    mq.delete();
    m_req     = 0;
    m_discard = 0;
    m_addr    = RESET_PC;
    m_next    = RESET_PC;
  endtask

  task automatic model_edge();
    bit acked;
    bit popping;
    acked   = m_req && iack;
    popping = (mq.size() != 0) && if_i_ready;
    if (flush) begin
      mq.delete();
      m_next = {redirect_pc[31:2], 2'b00};
      if (m_req && !iack) begin
        m_discard = 1;
      end else begin
        m_req     = 0;
        m_discard = 0;
      end
    end else begin
      if (popping) void'(mq.pop_front());
      if (acked) begin
        m_req = 0;
        if (m_discard) begin
          m_discard = 0;
        end else begin
          mq.push_back('{pc: m_addr, inst: irdata});
          m_next = m_addr + 32'd4;
        end
      end
    end
    // A new request goes out whenever the bus is free and there is room.
    if (!m_req && mq.size() < 2) begin
      m_req  = 1;
      m_addr = m_next;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_model(input string where);
    chk({where, ".ireq"}, 32'(ireq), 32'(m_req));
    if (m_req) chk({where, ".iaddr"}, iaddr, m_addr);
    chk({where, ".valid"}, 32'(if_o_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk({where, ".pc"}, if_o_pc, mq[0].pc);
      chk({where, ".inst"}, if_o_inst, mq[0].inst);
    end
  endtask

  // One clock edge: advance the model with the inputs the DUT sampled, then
  // compare 1 time unit after the edge.
  task automatic step(input string where);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    compare_model(where);
  endtask

  // Reset is asserted mid-cycle to show it acts without a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    iack  = 1'b0;
    flush = 1'b0;
    #1;
    model_reset();
    chk("rst.ireq", 32'(ireq), 32'd0);
    chk("rst.iaddr", iaddr, RESET_PC);
    chk("rst.valid", 32'(if_o_valid), 32'd0);
    chk("rst.inst", if_o_inst, 32'd0);
    chk("rst.pc", if_o_pc, 32'd0);
    step("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    // Streaming: iack tied high, ready high.
    do_reset();
    iack = 1'b1; if_i_ready = 1'b1; irdata = 32'h1111_0000;
    step("stream1");
    chk("stream1.iaddr", iaddr, 32'h0);
    chk("stream1.valid", 32'(if_o_valid), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      irdata = 32'h1111_0000 + 32'(i);
      step("stream");
      chk("stream.iaddr", iaddr, 32'(4 * i));
      chk("stream.pc", if_o_pc, 32'(4 * (i - 1)));
      chk("stream.valid", 32'(if_o_valid), 32'd1);
    end

    // Memory with 3 wait cycles.
    do_reset();
    iack = 1'b0; if_i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("wait");
      chk("wait.ireq", 32'(ireq), 32'd1);
      chk("wait.iaddr", iaddr, 32'h0);
    end
    iack = 1'b1; irdata = 32'hDEAD_BEEF;
    step("wait_ack");
    chk("wait_ack.valid", 32'(if_o_valid), 32'd1);
    chk("wait_ack.inst", if_o_inst, 32'hDEAD_BEEF);
    chk("wait_ack.pc", if_o_pc, 32'h0);

    // Back-pressure fills the queue, then HOLD.
    do_reset();
    iack = 1'b1; if_i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      irdata = 32'hA000_0000 + 32'(i);
      step("fill");
    end
    chk("hold.ireq", 32'(ireq), 32'd0);
    chk("hold.pc", if_o_pc, 32'h0);
    step("hold2");
    chk("hold2.ireq", 32'(ireq), 32'd0);
    if_i_ready = 1'b1;
    step("unhold");
    chk("unhold.ireq", 32'(ireq), 32'd1);
    chk("unhold.iaddr", iaddr, 32'h8);
    chk("unhold.pc", if_o_pc, 32'h4);

    // Flush while the fetch of 8 is pending: that word must be dropped.
    iack = 1'b0; flush = 1'b1; redirect_pc = 32'h0000_0103;
    step("flush_pend");
    flush = 1'b0;
    chk("flush_pend.iaddr", iaddr, 32'h8);
    chk("flush_pend.valid", 32'(if_o_valid), 32'd0);
    step("discard_wait");
    chk("discard_wait.iaddr", iaddr, 32'h8);
    iack = 1'b1; irdata = 32'hBAD0_0008;
    step("discard_ack");
    chk("discard_ack.iaddr", iaddr, 32'h100);
    chk("discard_ack.valid", 32'(if_o_valid), 32'd0);
    iack = 1'b0;
    step("redir_wait");
    chk("redir_wait.valid", 32'(if_o_valid), 32'd0);
    iack = 1'b1; irdata = 32'h0000_0100;
    step("redir_ack");
    chk("redir_ack.pc", if_o_pc, 32'h100);

    // Flush coinciding with iack and a pop while count is 1.
    do_reset();
    iack = 1'b1; if_i_ready = 1'b1;
    step("fp1");
    step("fp2");
    flush = 1'b1; redirect_pc = 32'h0000_0200;
    step("flush_ack_pop");
    chk("flush_ack_pop.valid", 32'(if_o_valid), 32'd0);
    chk("flush_ack_pop.iaddr", iaddr, 32'h200);

    // Wrap-around of the PC.
    redirect_pc = 32'hFFFF_FFFC;
    step("wrap_flush");
    chk("wrap_flush.iaddr", iaddr, 32'hFFFF_FFFC);
    flush = 1'b0;
    step("wrap1");
    chk("wrap1.iaddr", iaddr, 32'h0);
    chk("wrap1.pc", if_o_pc, 32'hFFFF_FFFC);
    step("wrap2");
    chk("wrap2.pc", if_o_pc, 32'h0);

    // Randomized traffic, including a mid-run asynchronous reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      iack        = 1'($urandom_range(0, 1));
      irdata      = $urandom;
      if_i_ready  = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                  : $urandom;
      step("rand");
      if (i == 1500) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage of the five-stage MIPS pipeline, feeding `regs_ifid` (and hence the `id_i_inst` input of the decode stage). It holds the PC, runs a single-outstanding req/ack handshake to instruction memory, and buffers returned words with their PCs in a 2-entry queue. The queue drains through a valid/ready handshake, and the stage supports a flush/redirect for future branch and jump logic. Memory words pass through unchanged; byte reordering is done in decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address; bits [1:0] must be 0.
- `cpu_clk_50M`, in, 1: the only clock; all logic is on the rising edge.
- `cpu_rst_n`, in, 1: asynchronous, active-low reset.
- `ireq`, out, 1: fetch request to instruction memory.
- `iaddr`, out, 32: fetch address, word aligned.
- `iack`, in, 1: `irdata` is valid this cycle and completes the request.
- `irdata`, in, 32: raw memory word in memory byte order.
- `flush`, in, 1: discard all buffered and in-flight fetches.
- `redirect_pc`, in, 32: new PC, sampled when `flush`=1; bits [1:0] are forced to 0.
- `if_o_valid`, out, 1: the queue head is presented on the outputs.
- `if_i_ready`, in, 1: `regs_ifid` accepts the head.
- `if_o_inst`, out, `inst_t`: head instruction word.
- `if_o_pc`, out, 32: PC of the head word.

## Operation
- FSM states:
  - `RST_HOLD`: entered on reset.
  - `FETCH`: `ireq`=1.
  - `HOLD`: queue full, no request.
  - `DISCARD`: draining an orphaned in-flight request after a flush.
- Transitions:
  - `RST_HOLD` goes to `FETCH` on the first clock edge after reset release.
  - `FETCH` with `iack`: push {`iaddr`, `irdata`} and set pc to pc+4.
    - Go to `HOLD` if the post-edge count is 2.
    - Otherwise stay in `FETCH`, with `iaddr` set to the new pc.
  - `HOLD` goes to `FETCH` once count < 2, including the cycle a pop makes it 1.
  - `DISCARD` with `iack`: drop the data and go to `FETCH` at the latched redirect pc.
- Handshake rules:
  - Once `ireq` is high, `ireq` and `iaddr` stay stable until `iack`.
  - At most one request is outstanding.
  - `iack` is legal in the first cycle `ireq` is high.
  - `iack` is ignored when `ireq`=0.
- Queue:
  - Count is 0..2.
  - `if_o_valid` = (count != 0).
  - Pop happens when `if_o_valid` and `if_i_ready`.
  - Push and pop in the same edge leave the count unchanged.
  - Overflow cannot occur: a request is issued only when count < 2, and only one request is in flight.
- Flush has priority over push and pop in the same cycle:
  - The queue is emptied and pc is loaded with {`redirect_pc`[31:2], 2'b00}.
  - With `ireq`=1 and no `iack` that cycle: go to `DISCARD`, and keep `iaddr` and `ireq` unchanged until `iack`.
  - With `iack` in the flush cycle, or `ireq`=0: go directly to `FETCH` at the redirect pc.
  - A flush while in `DISCARD` only updates the latched redirect pc.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values:
  - `ireq`=0, `iaddr`=`RESET_PC`.
  - `if_o_valid`=0, `if_o_inst`=0 (NOP), `if_o_pc`=0.
  - Count=0, state `RST_HOLD`.
- Reset mid-operation aborts everything immediately and asynchronously. Memory must tolerate the abandoned request.
- The first `ireq` rises one edge after `cpu_rst_n` deasserts.
- `iack` sampled at edge N makes the word visible, with `if_o_valid`=1, in cycle N+1.
- With `iack` tied high and `if_i_ready`=1, throughput is 1 instruction per cycle.
- `if_o_*` are registered; there is no combinational path from `iack`/`irdata` to the outputs.
- `if_i_ready` affects only queue state. `ireq` is registered and depends on the count only through the next edge.

## Structure
- Additions to `mips_cpu_pkg`:
  - `if_state_enum` with values RST_HOLD, FETCH, HOLD, DISCARD.
  - `fetch_entry_t` struct {`reg_t` pc; `inst_t` inst}.
  - Constant `IF_BUF_DEPTH` = 2.
- Sub-module `fetch_buf`: 2-entry FIFO of `fetch_entry_t` with push, pop, clear, count, and head outputs.
- The FSM and PC register stay in `stage_if`.

## Test plan
- Reset release with `iack` tied high and ready=1: `iaddr` goes 0, 4, 8, ….
  - `if_o_pc` follows one cycle later.
  - `if_o_valid` is high from cycle 2 on.
- `iack` after 3 wait cycles: `ireq` and `iaddr`=0 are held for 3 cycles, and the word appears on `if_o_inst` the cycle after `iack`.
- ready=0 with `iack` tied high: two words are buffered (pc 0, 4), then `ireq` drops (`HOLD`).
  - Raising ready pops pc 0 and re-issues `iaddr`=8.
- `flush` with `redirect_pc`=32'h0000_0103 while a request to 8 is pending:
  - `iaddr` stays 8 until `iack`, and that word is dropped.
  - Next `iaddr`=32'h0000_0100, and `if_o_valid`=0 until it returns.
- Flush in the same cycle as `iack` and a pop, with count=1: the queue becomes empty and the next `iaddr` is the redirect target.
- Redirect to 32'hFFFF_FFFC: consecutive fetches are FFFF_FFFC then 0000_0000.
